multicycle_control: RTL

Main control FSM for the multicycle MIPS datapath. Sequences fetch, decode, execute, memory and writeback over multiple clocks. Drives the datapath mux/enable controls and the aluop1/aluop0 pair consumed by the ALU control decoder. Stalls on a memory-ready handshake and keeps a retired-instruction counter.

---
 rtl/multicycle_control.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
`default_nettype none
// =============================================================================
// Module      : multicycle_control
// Description : Main control FSM for the multicycle MIPS datapath, with a
//               memory-ready stall handshake and a retired-instruction counter.
// Revision    : 1.0 - initial release
// =============================================================================
module multicycle_control #(
    parameter int CNT_W    = 32,
    parameter int FAST_MEM = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic             pcwrite,
    output logic             pcwritecond,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             memtoreg,
    output logic             irwrite,
    output logic [1:0]       pcsource,
    output logic             aluop1,
    output logic             aluop0,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic             regwrite,
    output logic             regdst,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [5:0] c_OP_R    = 6'b000000;
    localparam logic [5:0] c_OP_LW   = 6'b100011;
    localparam logic [5:0] c_OP_SW   = 6'b101011;
    localparam logic [5:0] c_OP_BEQ  = 6'b000100;
    localparam logic [5:0] c_OP_J    = 6'b000010;
    localparam logic [5:0] c_OP_ADDI = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    state_t           w_next;
    logic             w_retire;
    logic             w_rdy;

    assign w_rdy       = mem_ready | (FAST_MEM != 0);
    assign state       = r_state;
    assign instr_count = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    // Unreachable encodings fall through to the default and recover to FETCH.
    always_comb begin
        w_next   = S_FETCH;
        w_retire = 1'b0;
        case (r_state)
            S_FETCH:  w_next = w_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    c_OP_R:            w_next = S_EXEC;
                    c_OP_LW, c_OP_SW:  w_next = S_MEMADR;
                    c_OP_BEQ:          w_next = S_BRANCH;
                    c_OP_J:            w_next = S_JUMP;
                    c_OP_ADDI:         w_next = S_ADDIEX;
                    default:           w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == c_OP_LW) begin
                    w_next = S_MEMRD;
                end else if (op == c_OP_SW) begin
                    w_next = S_MEMWR;
                end
            end
            S_MEMRD:  w_next = w_rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR: begin
                w_next   = w_rdy ? S_FETCH : S_MEMWR;
                w_retire = w_rdy;
            end
            S_EXEC:   w_next = S_RWB;
            S_ADDIEX: w_next = S_ADDIWB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: w_retire = 1'b1;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;
        irwrite     = 1'b0;
        pcsource    = 2'b00;
        aluop1      = 1'b0;
        aluop0      = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        regwrite    = 1'b0;
        regdst      = 1'b0;
        illegal     = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    memread = 1'b1;
                    alusrcb = 2'b01;
                    irwrite = w_rdy;
                    pcwrite = w_rdy;
                end
                S_DECODE: begin
                    alusrcb = 2'b11;
                    illegal = !(op inside {c_OP_R, c_OP_LW, c_OP_SW,
                                           c_OP_BEQ, c_OP_J, c_OP_ADDI});
                end
                S_MEMADR, S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                S_MEMWR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                end
                S_EXEC: begin
                    alusrca = 1'b1;
                    aluop1  = 1'b1;
                end
                S_RWB: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                S_BRANCH: begin
                    alusrca     = 1'b1;
                    aluop0      = 1'b1;
                    pcwritecond = 1'b1;
                    pcsource    = 2'b01;
                end
                S_JUMP: begin
                    pcwrite  = 1'b1;
                    pcsource = 2'b10;
                end
                S_ADDIWB: regwrite = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
